// File: rtl/mem_addr_split_pkg.sv
// ---------------------------------------------------------------------------
// mem_addr_split_pkg : shared size/state encodings for the address splitter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_addr_split_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_W = 2'd1,
    SZ_L = 2'd2,
    SZ_Q = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WORD0 = 2'd1,
    ST_WORD1 = 2'd2
  } state_e;

  localparam int unsigned WORD_BYTES = 8;

  // Contiguous byte-enable pattern for an access of the given size at offset 0.
  function automatic logic [15:0] size_base_mask(input logic [1:0] size);
    logic [15:0] m;
    m = 16'h0000;
    case (size)
      SZ_B:    m = 16'h0001;
      SZ_W:    m = 16'h0003;
      SZ_L:    m = 16'h000F;
      SZ_Q:    m = 16'h00FF;
      default: m = 16'h0000;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_addr_split_mask.sv
// ---------------------------------------------------------------------------
// mem_addr_split_mask : size + byte offset -> 16-bit two-word mask, split flag
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_addr_split_mask
  import mem_addr_split_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [2:0]  offset,
  output logic [15:0] mask,
  output logic        split
);

  always_comb begin
    mask  = size_base_mask(size) << offset;
    split = |mask[15:8];
  end

endmodule

`default_nettype wire

// File: rtl/mem_addr_split.sv
// ---------------------------------------------------------------------------
// mem_addr_split : turns a sized byte access into one or two aligned 8-byte
//                  word requests with byte enables.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_addr_split
  import mem_addr_split_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [47:0] reqAddr,
  input  logic [7:0]  reqUIxt,
  input  logic        addrEnJq,
  output logic        memReqValid,
  input  logic        memReqReady,
  output logic [47:0] memReqAddr,
  output logic [7:0]  memReqMask,
  output logic        memReqLast,
  output logic [15:0] splitCount
);

  state_e      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        mem_valid_q, mem_valid_d;
  logic [47:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_mask_q, mem_mask_d;
  logic        mem_last_q, mem_last_d;
  logic [7:0]  hi_mask_q, hi_mask_d;
  logic        split_q, split_d;
  logic        wide_q, wide_d;
  logic [15:0] split_cnt_q, split_cnt_d;

  logic [15:0] new_mask;
  logic        new_split;
  logic [47:0] next_word_addr;
  logic        unused_uixt;

  assign unused_uixt = ^{reqUIxt[7:6], reqUIxt[3:0]};

  mem_addr_split_mask u_mask (
    .size   (reqUIxt[5:4]),
    .offset (reqAddr[2:0]),
    .mask   (new_mask),
    .split  (new_split)
  );

  // In 32-bit mode the carry out of bit 31 is dropped and the top stays zero.
  always_comb begin
    if (wide_q) begin
      next_word_addr = mem_addr_q + 48'(WORD_BYTES);
    end else begin
      next_word_addr = {16'h0000, mem_addr_q[31:0] + 32'(WORD_BYTES)};
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_mask_d  = mem_mask_q;
    mem_last_d  = mem_last_q;
    hi_mask_d   = hi_mask_q;
    split_d     = split_q;
    wide_d      = wide_q;
    split_cnt_d = split_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (reqValid && req_ready_q) begin
          state_d     = ST_WORD0;
          req_ready_d = 1'b0;
          mem_valid_d = 1'b1;
          mem_addr_d  = addrEnJq ? {reqAddr[47:3], 3'b000}
                                 : {16'h0000, reqAddr[31:3], 3'b000};
          mem_mask_d  = new_mask[7:0];
          mem_last_d  = ~new_split;
          hi_mask_d   = new_mask[15:8];
          split_d     = new_split;
          wide_d      = addrEnJq;
        end else begin
          req_ready_d = 1'b1;
        end
      end

      ST_WORD0: begin
        if (memReqReady) begin
          if (split_q) begin
            state_d    = ST_WORD1;
            mem_addr_d = next_word_addr;
            mem_mask_d = hi_mask_q;
            mem_last_d = 1'b1;
            if (split_cnt_q != 16'hFFFF) begin
              split_cnt_d = split_cnt_q + 16'd1;
            end
          end else begin
            state_d     = ST_IDLE;
            req_ready_d = 1'b1;
            mem_valid_d = 1'b0;
            mem_addr_d  = '0;
            mem_mask_d  = '0;
            mem_last_d  = 1'b0;
          end
        end
      end

      ST_WORD1: begin
        if (memReqReady) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
          mem_valid_d = 1'b0;
          mem_addr_d  = '0;
          mem_mask_d  = '0;
          mem_last_d  = 1'b0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b0;
        mem_valid_d = 1'b0;
        mem_addr_d  = '0;
        mem_mask_d  = '0;
        mem_last_d  = 1'b0;
      end
    endcase
  end

  // reqReady resets low so it first rises on the edge after reset release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_mask_q  <= '0;
      mem_last_q  <= 1'b0;
      hi_mask_q   <= '0;
      split_q     <= 1'b0;
      wide_q      <= 1'b0;
      split_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_mask_q  <= mem_mask_d;
      mem_last_q  <= mem_last_d;
      hi_mask_q   <= hi_mask_d;
      split_q     <= split_d;
      wide_q      <= wide_d;
      split_cnt_q <= split_cnt_d;
    end
  end

  assign reqReady    = req_ready_q;
  assign memReqValid = mem_valid_q;
  assign memReqAddr  = mem_addr_q;
  assign memReqMask  = mem_mask_q;
  assign memReqLast  = mem_last_q;
  assign splitCount  = split_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_addr_split.sv
// ---------------------------------------------------------------------------
// tb_mem_addr_split : scoreboard bench for mem_addr_split
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_addr_split;

  typedef struct packed {
    logic [47:0] a;
    logic [7:0]  m;
    logic        l;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic [47:0] reqAddr;
  logic [7:0]  reqUIxt;
  logic        addrEnJq;
  logic        memReqValid;
  logic        memReqReady;
  logic [47:0] memReqAddr;
  logic [7:0]  memReqMask;
  logic        memReqLast;
  logic [15:0] splitCount;

  logic        rdy_sel;
  logic        rdy_val;
  logic        rdy_rand = 1'b1;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          exp_split = 0;

  always #5 clock = ~clock;
  always @(posedge clock) rdy_rand <= 1'($urandom_range(0, 1));
  assign memReqReady = rdy_sel ? rdy_rand : rdy_val;

  mem_addr_split dut (
    .clock       (clock),
    .reset       (reset),
    .reqValid    (reqValid),
    .reqReady    (reqReady),
    .reqAddr     (reqAddr),
    .reqUIxt     (reqUIxt),
    .addrEnJq    (addrEnJq),
    .memReqValid (memReqValid),
    .memReqReady (memReqReady),
    .memReqAddr  (memReqAddr),
    .memReqMask  (memReqMask),
    .memReqLast  (memReqLast),
    .splitCount  (splitCount)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Every accepted memory word is compared against the oldest expectation.
  always @(negedge clock) begin
    if (reset === 1'b1 && memReqValid && memReqReady) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", {16'h0, memReqAddr}, 64'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("word_addr", {16'h0, memReqAddr}, {16'h0, e.a});
        chk("word_mask", {56'h0, memReqMask}, {56'h0, e.m});
        chk("word_last", {63'h0, memReqLast}, {63'h0, e.l});
      end
    end
  end

  task automatic send(input logic [47:0] a, input logic [1:0] sz, input logic en);
    logic [15:0] base, m;
    logic [47:0] w0, w1;
    int          n;
    exp_t        e;
    base = (16'h1 << (1 << sz)) - 16'h1;
    m    = base << a[2:0];
    w0   = en ? {a[47:3], 3'b000} : {16'h0, a[31:3], 3'b000};
    w1   = en ? (w0 + 48'd8) : {16'h0, w0[31:0] + 32'd8};
    e.a = w0; e.m = m[7:0]; e.l = ~(|m[15:8]);
    sb.push_back(e);
    if (|m[15:8]) begin
      e.a = w1; e.m = m[15:8]; e.l = 1'b1;
      sb.push_back(e);
      exp_split++;
    end
    n = 0;
    while (!reqReady && n < 100) begin
      @(posedge clock); #1; n++;
    end
    if (n >= 100) chk("accept_timeout", 64'h0, 64'h1);
    reqValid = 1'b1;
    reqAddr  = a;
    reqUIxt  = {2'b11, sz, 4'hA};
    addrEnJq = en;
    @(posedge clock); #1;
    reqValid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !reqReady) && n < 300) begin
      @(posedge clock); #1; n++;
    end
    if (n >= 300) chk("drain_timeout", 64'h0, 64'h1);
  endtask

  initial begin
    reset    = 1'b0;
    reqValid = 1'b0;
    reqAddr  = '0;
    reqUIxt  = '0;
    addrEnJq = 1'b1;
    rdy_sel  = 1'b0;
    rdy_val  = 1'b1;

    #12;
    chk("rst_valid", {63'h0, memReqValid}, 64'h0);
    chk("rst_addr", {16'h0, memReqAddr}, 64'h0);
    chk("rst_mask", {56'h0, memReqMask}, 64'h0);
    chk("rst_last", {63'h0, memReqLast}, 64'h0);
    chk("rst_count", {48'h0, splitCount}, 64'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("ready_after_rst", {63'h0, reqReady}, 64'h1);

    send(48'h0000_1000_0004, 2'd2, 1'b1);
    drain();
    chk("count_single", {48'h0, splitCount}, 64'd0);
    chk("idle_valid", {63'h0, memReqValid}, 64'h0);
    chk("idle_addr", {16'h0, memReqAddr}, 64'h0);
    chk("idle_mask", {56'h0, memReqMask}, 64'h0);

    send(48'h0000_1000_0006, 2'd2, 1'b1);
    drain();
    chk("count_split", {48'h0, splitCount}, 64'd1);

    send(48'hFFFF_FFFF_FFFC, 2'd3, 1'b1);
    drain();
    chk("count_wrap48", {48'h0, splitCount}, 64'd2);

    send(48'h1234_FFFF_FFFF, 2'd1, 1'b0);
    drain();
    chk("count_wrap32", {48'h0, splitCount}, 64'd3);

    rdy_sel = 1'b1;
    for (int i = 0; i < 20; i++) begin
      logic [63:0] r;
      r = {$urandom, $urandom};
      send(r[47:0], 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    rdy_sel = 1'b0;
    rdy_val = 1'b1;
    drain();
    chk("count_random", {48'h0, splitCount}, 64'(exp_split));

    // Back-pressure in WORD0; a stray request meanwhile must be ignored.
    rdy_val = 1'b0;
    send(48'h0000_2000_0006, 2'd2, 1'b1);
    chk("hold_valid_rise", {63'h0, memReqValid}, 64'h1);
    reqValid = 1'b1;
    reqAddr  = 48'h0000_5555_0001;
    reqUIxt  = 8'h30;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {63'h0, memReqValid}, 64'h1);
      chk("hold_addr", {16'h0, memReqAddr}, 64'h0000_2000_0000);
      chk("hold_mask", {56'h0, memReqMask}, 64'hC0);
      chk("hold_last", {63'h0, memReqLast}, 64'h0);
      chk("hold_ready", {63'h0, reqReady}, 64'h0);
      @(posedge clock); #1;
    end
    reqValid = 1'b0;
    rdy_val  = 1'b1;
    @(posedge clock); #1;
    chk("hold_word1_addr", {16'h0, memReqAddr}, 64'h0000_2000_0008);
    chk("hold_word1_mask", {56'h0, memReqMask}, 64'h03);
    chk("hold_word1_last", {63'h0, memReqLast}, 64'h1);
    drain();
    chk("count_hold", {48'h0, splitCount}, 64'(exp_split));

    // Reset while WORD1 is pending.
    rdy_val = 1'b0;
    send(48'h0000_3000_0007, 2'd3, 1'b1);
    rdy_val = 1'b1;
    @(posedge clock); #1;
    rdy_val = 1'b0;
    chk("mid_word1_valid", {63'h0, memReqValid}, 64'h1);
    chk("mid_word1_last", {63'h0, memReqLast}, 64'h1);
    reset = 1'b0;
    #1;
    chk("async_valid", {63'h0, memReqValid}, 64'h0);
    chk("async_addr", {16'h0, memReqAddr}, 64'h0);
    chk("async_mask", {56'h0, memReqMask}, 64'h0);
    chk("async_count", {48'h0, splitCount}, 64'h0);
    sb.delete();
    exp_split = 0;
    @(posedge clock); #1;
    reset   = 1'b1;
    rdy_val = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_ready", {63'h0, reqReady}, 64'h1);
    for (int i = 0; i < 5; i++) begin
      chk("post_rst_no_word", {63'h0, memReqValid}, 64'h0);
      @(posedge clock); #1;
    end
    chk("post_rst_count", {48'h0, splitCount}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_addr_split.md
MEM_ADDR_SPLIT -- requirements
Module: mem_addr_split

Interface
REQ-001 SHALL have port: clock  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: reqValid  input  1  upstream access request valid.
REQ-004 SHALL have port: reqReady  output  1  block can accept a request this cycle.
REQ-005 SHALL have port: reqAddr  input  48  byte address, as produced by the address-generation stage.
REQ-006 SHALL have port: reqUIxt  input  8  access control; [5:4] size B/W/L/Q = 1/2/4/8 bytes, other bits ignored.
REQ-007 SHALL have port: addrEnJq  input  1  1 = 48-bit address space; 0 = 32-bit space, with output bits [47:32] forced to zero.
REQ-008 SHALL have port: memReqValid  output  1  aligned word request valid.
REQ-009 SHALL have port: memReqReady  input  1  memory side accepts the request.
REQ-010 SHALL have port: memReqAddr  output  48  8-byte-aligned address, bits [2:0] always 0.
REQ-011 SHALL have port: memReqMask  output  8  byte-enable within the aligned word.
REQ-012 SHALL have port: memReqLast  output  1  this is the final word of the current access.
REQ-013 SHALL have port: splitCount  output  16  count of accesses that required two words.

Function
REQ-014 SHALL implement FSM states IDLE, WORD0, WORD1.
REQ-015 SHALL drive reqReady=1 only in IDLE.
REQ-016 SHALL accept on reqValid&reqReady, capturing address, size and addrEnJq.
REQ-017 SHALL enter WORD0 on the cycle after acceptance, so memReqValid first rises one cycle after acceptance.
REQ-018 SHALL form a 16-bit mask M = ((1<<size)-1) << addr[2:0].
REQ-019 SHALL set split = |M[15:8].
REQ-020 SHALL present in WORD0: memReqAddr={addr[47:3],3'b0}, memReqMask=M[7:0], memReqLast=!split.
REQ-021 SHALL present in WORD1: memReqAddr=word0 address + 8, memReqMask=M[15:8], memReqLast=1.
REQ-022 SHALL compute the WORD1 address modulo 2^48 when addrEnJq=1, so 48'hFFFF_FFFF_FFF8+8 wraps to 0.
REQ-023 SHALL compute the WORD1 address modulo 2^32 when addrEnJq=0, with memReqAddr[47:32]=0 in both words.
REQ-024 SHALL keep memReqValid, memReqAddr, memReqMask and memReqLast stable while memReqValid&!memReqReady.
REQ-025 SHALL transition WORD0 -> WORD1 on memReqReady when split, otherwise WORD0 -> IDLE.
REQ-026 SHALL transition WORD1 -> IDLE on memReqReady.
REQ-027 SHALL drive all outputs from registers, with no combinational path from memReqReady to memReqValid.
REQ-028 SHALL increment splitCount when the WORD0 handshake completes with split=1, saturating at 16'hFFFF.
REQ-029 SHALL ignore reqValid outside IDLE; upstream holds the request since reqReady=0.
REQ-030 SHALL deassert memReqValid in IDLE; memReqAddr and memReqMask SHALL be 0 there.

Reset
REQ-031 SHALL on reset=0, immediately and independent of clock, force state=IDLE, memReqValid=0, memReqAddr=0, memReqMask=0, memReqLast=0, splitCount=0.
REQ-032 SHALL abandon any in-progress access on reset assertion mid-operation; the second word is never issued after release.
REQ-033 SHALL drive reqReady=1 on the first clock edge after reset release.

Structure
REQ-034 SHALL place in a shared package the size encodings (B/W/L/Q), the FSM state encodings, and word-size constant 8.
REQ-035 SHALL contain one sub-module, mem_addr_split_mask (combinational size+offset -> 16-bit mask and split flag); all other logic SHALL be flat.

Verification
REQ-036 SHALL cover: addr=48'h0000_1000_0004, size L, memReqReady=1 -> one word, addr 48'h0000_1000_0000, mask 8'hF0, last=1, splitCount unchanged.
REQ-037 SHALL cover: addr=48'h0000_1000_0006, size L -> word0 addr ..._1000_0000 mask 8'hC0 last=0; word1 addr ..._1000_0008 mask 8'h03 last=1; splitCount=1.
REQ-038 SHALL cover: addr=48'hFFFF_FFFF_FFFC, size Q, addrEnJq=1 -> word0 48'hFFFF_FFFF_FFF8 mask 8'hF0; word1 48'h0 mask 8'h0F.
REQ-039 SHALL cover: addr=48'h1234_FFFF_FFFF, size W, addrEnJq=0 -> word0 48'h0000_FFFF_FFF8 mask 8'h80; word1 48'h0 mask 8'h01.
REQ-040 SHALL cover: memReqReady held 0 for 5 cycles in WORD0 of a split access -> outputs stable, reqReady=0; then ready=1 -> WORD1 next cycle.
REQ-041 SHALL cover: reset=0 asserted while in WORD1 -> memReqValid=0 without a clock edge; after release no second word issued, reqReady=1, splitCount=0.
